sys_bridge_resp: RTL and testbench
==================================

// Module: sys_bridge_resp
// PURPOSE
//  Responder side of the CPU data-port: decodes CPUDataAddr, executes byte-enabled writes and returns read data.
//  Holds the data-memory array plus two timers (Timer0, Timer1) and the external-interrupt acknowledge port.
//  Sits between the CPU M-stage memory interface and the memory-mapped devices; collects device IRQs into HWInt.
// PARAMETERS
//  DM_WORDS    3072   data-memory depth in 32-bit words (byte range 0x0000..0x2fff)
//  T0_BASE     32'h7f00  Timer0 base (CTRL +0, PRESET +4, COUNT +8)
//  T1_BASE     32'h7f10  Timer1 base, same layout
//  IG_BASE     32'h7f20  interrupt-generator acknowledge word (0x7f20..0x7f23)
// PORTS
//  clk            in   1   system clock, all state on posedge
//  rst_n          in   1   asynchronous active-low reset
//  CPUDataAddr    in   32  byte address from the CPU
//  CPUWriteData   in   32  write data, already lane-aligned by the CPU
//  CPUDataByteEn  in   4   byte-lane write enables; 4'b0000 = read / no write
//  dataIn         out  32  read data to the CPU (combinational from address)
//  extInt         in   1   level interrupt from the external generator
//  intAck         out  1   1-cycle acknowledge pulse to the generator
//  HWInt          out  6   {3'b0, extInt, t1_irq, t0_irq} to CP0
// BEHAVIOUR
//  Reset: all DM words 0; timer CTRL/PRESET/COUNT 0, FSM IDLE, irq flags 0; intAck 0; HWInt = {3'b0, extInt, 2'b0}.
//  Decode: DM when Addr < DM_WORDS*4; timer regs on word match (Addr[31:2]); IG on 0x7f20..0x7f23; else unmapped.
//  Reads: zero latency; dataIn = word at {Addr[31:2],2'b00}; lane extraction is the CPU's job.
//   COUNT readable; IG and unmapped read 32'h0.
//  DM write: posedge, each lane i written iff ByteEn[i]; read in the write cycle returns old data.
//  Timer write: accepted only when ByteEn == 4'b1111, else ignored. COUNT is read-only.
//   CTRL keeps bits [3:0] only (upper bits read 0).
//   CTRL[0] = EN, CTRL[2:1] = MODE (00 one-shot, 01 auto-reload, others = one-shot), CTRL[3] = IM.
//   Any accepted CTRL/PRESET write forces the FSM to IDLE and clears the irq flag in the same edge.
//  Timer FSM (per timer; CPU write has priority over FSM step):
//   IDLE: EN -> LOAD.
//   LOAD: COUNT <= PRESET -> CNT.
//   CNT: !EN -> IDLE (COUNT frozen). COUNT > 1 -> COUNT-1. COUNT <= 1 -> COUNT <= 0, flag <= 1 -> INT.
//   INT: MODE 00 -> EN <= 0, -> IDLE, flag held until next CTRL/PRESET write.
//        MODE 01 -> flag <= 0, -> IDLE; the cycle after, EN still set, so reload follows.
//   PRESET 0 or 1: LOAD -> CNT -> INT, i.e. flag 3 edges after enable.
//   Wrap-around: none; COUNT never underflows below 0.
//  t_irq = flag & IM (combinational); MODE 01 gives a 1-cycle pulse, MODE 00 gives a level.
//  intAck: high for exactly the cycle after any write with ByteEn != 0 to 0x7f20..0x7f23.
//   Back-to-back writes give back-to-back pulses.
//  Unmapped writes: no state change. rst_n low mid-count: immediate return to reset values.
// STRUCTURE
//  Shared package/include: address map constants (DM end, T0/T1/IG base), timer register offsets,
//   CTRL bit positions, MODE encodings, FSM state encodings.
//  One sub-module: timer_unit (CTRL/PRESET/COUNT, FSM, irq), instantiated twice.
//  DM array and address decode stay in the top level.
// TESTING
//  Reset release: read 0x0000 and 0x7f08 -> dataIn 0, HWInt 0, intAck 0.
//  DM lanes: write 0x11223344 @0x10 BE 1111, then 0x0000AA00 BE 0010 -> read 0x1122AA44.
//   Read during the write cycle returns the old value.
//  Timer0 one-shot: PRESET=5, CTRL=0x9 -> COUNT 5,4,3,2,1,0; HWInt[0]=1 held.
//   CTRL reads 0x8 after INT; writing CTRL=0x9 clears HWInt[0].
//  Timer1 auto-reload: PRESET=3, CTRL=0xB -> HWInt[1] is a 1-cycle pulse, repeating every 6 cycles.
//   Clearing EN mid-count freezes COUNT.
//  Priority / partial write: PRESET write in the same cycle the count reaches 1 -> no IRQ, state IDLE.
//   Timer write with BE 0011 is ignored.
//  IG: extInt=1 -> HWInt[2]=1. SB to 0x7f22 -> intAck high exactly one cycle.
//   Read of 0x7f24 -> 0.

Source files
------------

// File: rtl/sys_bridge_resp_pkg.sv
// rtl/sys_bridge_resp_pkg.sv - address map, timer register offsets, CTRL fields and FSM encodings
package sys_bridge_resp_pkg;

    localparam int          DM_WORDS_DEF = 3072;
    localparam logic [31:0] T0_BASE_DEF  = 32'h0000_7f00;
    localparam logic [31:0] T1_BASE_DEF  = 32'h0000_7f10;
    localparam logic [31:0] IG_BASE_DEF  = 32'h0000_7f20;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CNT  = 2'd2;
    localparam logic [1:0] ST_INT  = 2'd3;

    // Only MODE 01 reloads; every other encoding behaves as one-shot.
    function automatic logic is_reload(input logic [3:0] ctrl);
        return ctrl[CTRL_MODE_LSB +: 2] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/sys_bridge_resp_timer_unit.sv
// rtl/sys_bridge_resp_timer_unit.sv - one down-counting timer: CTRL/PRESET/COUNT, FSM and irq
module timer_unit
    import sys_bridge_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  reg_idx,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        flag;
    logic        wr_ctrl;
    logic        wr_preset;

    assign wr_ctrl   = wr && (reg_idx == REG_CTRL);
    assign wr_preset = wr && (reg_idx == REG_PRESET);

    // A CPU write to CTRL/PRESET pre-empts the FSM step of the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl   <= '0;
            preset <= '0;
            count  <= '0;
            state  <= ST_IDLE;
            flag   <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            if (wr_ctrl) begin
                ctrl <= wdata[3:0];
            end
            if (wr_preset) begin
                preset <= wdata;
            end
            state <= ST_IDLE;
            flag  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl[CTRL_EN]) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl[CTRL_EN]) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= '0;
                        flag  <= 1'b1;
                        state <= ST_INT;
                    end
                end
                default: begin
                    if (is_reload(ctrl)) begin
                        flag <= 1'b0;
                    end else begin
                        ctrl[CTRL_EN] <= 1'b0;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_CTRL:   rdata = {28'd0, ctrl};
            REG_PRESET: rdata = preset;
            REG_COUNT:  rdata = count;
            default:    rdata = '0;
        endcase
    end

    assign irq = flag & ctrl[CTRL_IM];

endmodule

// File: rtl/sys_bridge_resp.sv
// rtl/sys_bridge_resp.sv - CPU data-port responder: data memory, two timers, interrupt acknowledge
module sys_bridge_resp
    import sys_bridge_resp_pkg::*;
#(
    parameter int          DM_WORDS = DM_WORDS_DEF,
    parameter logic [31:0] T0_BASE  = T0_BASE_DEF,
    parameter logic [31:0] T1_BASE  = T1_BASE_DEF,
    parameter logic [31:0] IG_BASE  = IG_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] CPUDataAddr,
    input  logic [31:0] CPUWriteData,
    input  logic [3:0]  CPUDataByteEn,
    output logic [31:0] dataIn,
    input  logic        extInt,
    output logic        intAck,
    output logic [5:0]  HWInt
);

    localparam int          DM_AW    = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(DM_WORDS * 4);

    logic [31:0]         dm [DM_WORDS];
    logic [DM_WORDS-1:0] dm_valid;
    logic [DM_AW-1:0]    dm_idx;
    logic                dm_hit;
    logic                dm_we;
    logic [31:0]         dm_rd;
    logic [31:0]         dm_wword;
    logic                t0_hit;
    logic                t1_hit;
    logic                ig_hit;
    logic                full_word;
    logic [31:0]         t0_rdata;
    logic [31:0]         t1_rdata;
    logic                t0_irq;
    logic                t1_irq;

    assign dm_hit    = CPUDataAddr < DM_BYTES;
    assign dm_idx    = CPUDataAddr[DM_AW+1:2];
    assign t0_hit    = CPUDataAddr[31:4] == T0_BASE[31:4];
    assign t1_hit    = CPUDataAddr[31:4] == T1_BASE[31:4];
    assign ig_hit    = CPUDataAddr[31:2] == IG_BASE[31:2];
    assign full_word = CPUDataByteEn == 4'hf;
    assign dm_we     = dm_hit && (CPUDataByteEn != 4'h0);

    // Per-word valid bits give the array a reset value of zero without clearing every word.
    assign dm_rd = (dm_hit && dm_valid[dm_idx]) ? dm[dm_idx] : 32'd0;

    always_comb begin
        dm_wword = dm_rd;
        for (int b = 0; b < 4; b++) begin
            if (CPUDataByteEn[b]) begin
                dm_wword[8*b +: 8] = CPUWriteData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dm_we) begin
            dm[dm_idx] <= dm_wword;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_valid <= '0;
        end else if (dm_we) begin
            dm_valid[dm_idx] <= 1'b1;
        end
    end

    timer_unit u_timer0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .reg_idx (CPUDataAddr[3:2]),
        .wr      (t0_hit && full_word),
        .wdata   (CPUWriteData),
        .rdata   (t0_rdata),
        .irq     (t0_irq)
    );

    timer_unit u_timer1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .reg_idx (CPUDataAddr[3:2]),
        .wr      (t1_hit && full_word),
        .wdata   (CPUWriteData),
        .rdata   (t1_rdata),
        .irq     (t1_irq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intAck <= 1'b0;
        end else begin
            intAck <= ig_hit && (CPUDataByteEn != 4'h0);
        end
    end

    always_comb begin
        dataIn = 32'd0;
        if (dm_hit) begin
            dataIn = dm_rd;
        end else if (t0_hit) begin
            dataIn = t0_rdata;
        end else if (t1_hit) begin
            dataIn = t1_rdata;
        end
    end

    assign HWInt = {3'b000, extInt, t1_irq, t0_irq};

endmodule

// File: tb/tb_sys_bridge_resp.sv
// tb/tb_sys_bridge_resp.sv - randomized and directed bench for sys_bridge_resp against a behavioural model
module tb_sys_bridge_resp;

    localparam int DMW = 3072;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] CPUDataAddr;
    logic [31:0] CPUWriteData;
    logic [3:0]  CPUDataByteEn;
    logic [31:0] dataIn;
    logic        extInt;
    logic        intAck;
    logic [5:0]  HWInt;

    int total = 0;
    int bad   = 0;

    longint      cyc;
    logic [31:0] mdm [DMW];
    logic [3:0]  m_ctrl   [2];
    logic [31:0] m_preset [2];
    logic [31:0] m_cnt0   [2];
    longint      m_anchor [2];
    logic        m_ack;

    int os_cnt [10] = '{0, 0, 5, 4, 3, 2, 1, 0, 0, 0};

    sys_bridge_resp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CPUDataAddr   (CPUDataAddr),
        .CPUWriteData  (CPUWriteData),
        .CPUDataByteEn (CPUDataByteEn),
        .dataIn        (dataIn),
        .extInt        (extInt),
        .intAck        (intAck),
        .HWInt         (HWInt)
    );

    always #5 clk = ~clk;

    // Timer model: a run starts at the edge of the last accepted CTRL/PRESET write (the anchor);
    // everything afterwards is a closed-form function of the edges elapsed since then.
    function automatic longint eff_p(int t);
        return (m_preset[t] <= 32'd1) ? 64'd1 : longint'(m_preset[t]);
    endfunction

    function automatic logic reload(int t);
        return m_ctrl[t][2:1] == 2'b01;
    endfunction

    function automatic longint phase(int t, longint n);
        longint d;
        d = n - m_anchor[t];
        if (reload(t) && d >= 1) return (d - 1) % (eff_p(t) + 3) + 1;
        return d;
    endfunction

    function automatic logic [31:0] t_count(int t, longint n);
        longint d;
        longint m;
        d = n - m_anchor[t];
        m = phase(t, n);
        if (!m_ctrl[t][0] || d < 2) return m_cnt0[t];
        if (m == 1) return 32'd0;
        if (m <= eff_p(t) + 1) return m_preset[t] - 32'(m - 2);
        return 32'd0;
    endfunction

    function automatic logic t_flag(int t, longint n);
        longint d;
        longint m;
        d = n - m_anchor[t];
        m = phase(t, n);
        if (!m_ctrl[t][0] || d < 2) return 1'b0;
        if (reload(t)) return m == eff_p(t) + 2;
        return m >= eff_p(t) + 2;
    endfunction

    function automatic logic [3:0] t_ctrl(int t, longint n);
        logic [3:0] c;
        c = m_ctrl[t];
        if (c[0] && !reload(t) && (n - m_anchor[t]) >= eff_p(t) + 3) c[0] = 1'b0;
        return c;
    endfunction

    function automatic logic [31:0] exp_rd(logic [31:0] a, longint n);
        int t;
        if (a < 32'h3000) return mdm[a[13:2]];
        if (a[31:4] == 28'h00007f0 || a[31:4] == 28'h00007f1) begin
            t = int'(a[4]);
            case (a[3:2])
                2'd0:    return {28'd0, t_ctrl(t, n)};
                2'd1:    return m_preset[t];
                2'd2:    return t_count(t, n);
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    function automatic logic [5:0] exp_hw(longint n);
        return {3'b000, extInt, t_flag(1, n) & m_ctrl[1][3], t_flag(0, n) & m_ctrl[0][3]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < DMW; i++) mdm[i] = 32'd0;
        for (int t = 0; t < 2; t++) begin
            m_ctrl[t]   = 4'd0;
            m_preset[t] = 32'd0;
            m_cnt0[t]   = 32'd0;
            m_anchor[t] = 0;
        end
        m_ack = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        int          t;
        logic [31:0] c0;
        logic [3:0]  k0;
        m_ack = (a >= 32'h7f20) && (a <= 32'h7f23) && (be != 4'd0);
        if (a < 32'h3000) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mdm[a[13:2]][8*b +: 8] = wd[8*b +: 8];
            end
        end else if ((a[31:4] == 28'h00007f0 || a[31:4] == 28'h00007f1) && be == 4'hf && a[3:2] <= 2'd1) begin
            t  = int'(a[4]);
            c0 = t_count(t, cyc);
            k0 = t_ctrl(t, cyc);
            m_cnt0[t] = c0;
            m_ctrl[t] = k0;
            if (a[3:2] == 2'd0) m_ctrl[t] = wd[3:0];
            else                m_preset[t] = wd;
            m_anchor[t] = cyc + 1;
        end
        cyc++;
    endtask

    // Every cycle: apply inputs, let combinational read settle, compare all outputs with the model.
    task automatic set_in(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        CPUDataAddr   = a;
        CPUWriteData  = wd;
        CPUDataByteEn = be;
        #1;
        chk("rd", dataIn, exp_rd(a, cyc));
        chk("hwint", 32'(HWInt), 32'(exp_hw(cyc)));
        chk("ack", 32'(intAck), 32'(m_ack));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(CPUDataAddr, CPUWriteData, CPUDataByteEn);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  hw;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          r;
        rst_n = 1'b0;
        CPUDataAddr = 32'd0;
        CPUWriteData = 32'd0;
        CPUDataByteEn = 4'd0;
        extInt = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        set_in(32'h0000, 32'd0, 4'd0);
        chk("rst_dm0", dataIn, 32'd0);
        chk("rst_hwint", 32'(HWInt), 32'd0);
        chk("rst_ack", 32'(intAck), 32'd0);
        tick();
        set_in(32'h7f08, 32'd0, 4'd0);
        chk("rst_count", dataIn, 32'd0);
        tick();

        set_in(32'h10, 32'h11223344, 4'hf);
        chk("dm_old_in_write", dataIn, 32'd0);
        tick();
        set_in(32'h10, 32'h0000aa00, 4'b0010);
        chk("dm_old_in_lane_write", dataIn, 32'h11223344);
        tick();
        set_in(32'h10, 32'd0, 4'd0);
        chk("dm_lane_merge", dataIn, 32'h1122aa44);
        chk("model_dm_lane", exp_rd(32'h10, cyc), 32'h1122aa44);
        tick();

        set_in(32'h7f04, 32'd5, 4'hf); tick();
        set_in(32'h7f00, 32'h9, 4'hf); tick();
        for (int k = 0; k < 10; k++) begin
            set_in(32'h7f08, 32'd0, 4'd0);
            chk("os_count", dataIn, 32'(os_cnt[k]));
            chk("model_os_count", exp_rd(32'h7f08, cyc), 32'(os_cnt[k]));
            chk("os_irq", 32'(HWInt[0]), 32'(k >= 7));
            tick();
        end
        set_in(32'h7f00, 32'd0, 4'd0);
        chk("os_ctrl_after", dataIn, 32'h8);
        tick();
        set_in(32'h7f00, 32'h9, 4'hf); tick();
        set_in(32'h7f08, 32'd0, 4'd0);
        chk("os_irq_clear", 32'(HWInt[0]), 32'd0);
        tick();
        set_in(32'h7f00, 32'd0, 4'hf); tick();

        set_in(32'h7f14, 32'd3, 4'hf); tick();
        set_in(32'h7f10, 32'hb, 4'hf); tick();
        for (int k = 0; k < 15; k++) begin
            set_in(32'h7f18, 32'd0, 4'd0);
            hw = exp_hw(cyc);
            chk("ar_irq", 32'(HWInt[1]), 32'(k == 5 || k == 11));
            chk("model_ar_irq", 32'(hw[1]), 32'(k == 5 || k == 11));
            tick();
        end
        set_in(32'h7f10, 32'ha, 4'hf); tick();
        for (int k = 0; k < 3; k++) begin
            set_in(32'h7f18, 32'd0, 4'd0);
            chk("ar_freeze", dataIn, 32'd2);
            tick();
        end

        set_in(32'h7f04, 32'd3, 4'hf); tick();
        set_in(32'h7f00, 32'h9, 4'hf); tick();
        for (int k = 0; k < 4; k++) begin
            set_in(32'h7f08, 32'd0, 4'd0); tick();
        end
        set_in(32'h7f08, 32'd0, 4'd0);
        chk("pri_count_at_1", dataIn, 32'd1);
        set_in(32'h7f04, 32'd100, 4'hf); tick();
        set_in(32'h7f08, 32'd0, 4'd0);
        chk("pri_count_held", dataIn, 32'd1);
        chk("pri_no_irq", 32'(HWInt[0]), 32'd0);
        tick();
        set_in(32'h7f08, 32'd0, 4'd0); tick();
        set_in(32'h7f08, 32'd0, 4'd0);
        chk("pri_reload", dataIn, 32'd100);
        tick();
        set_in(32'h7f04, 32'h55, 4'b0011); tick();
        set_in(32'h7f04, 32'd0, 4'd0);
        chk("partial_ignored", dataIn, 32'd100);
        tick();
        set_in(32'h7f00, 32'd0, 4'hf); tick();

        extInt = 1'b1;
        set_in(32'h7f24, 32'd0, 4'd0);
        chk("ig_past_end", dataIn, 32'd0);
        chk("ext_irq", 32'(HWInt[2]), 32'd1);
        tick();
        set_in(32'h7f22, 32'h00ab0000, 4'b0100);
        chk("ack_before", 32'(intAck), 32'd0);
        tick();
        set_in(32'h0, 32'd0, 4'd0);
        chk("ack_pulse", 32'(intAck), 32'd1);
        tick();
        set_in(32'h0, 32'd0, 4'd0);
        chk("ack_end", 32'(intAck), 32'd0);
        tick();
        extInt = 1'b0;

        set_in(32'h7f04, 32'd40, 4'hf); tick();
        set_in(32'h7f00, 32'h1, 4'hf); tick();
        repeat (6) begin
            set_in(32'h7f08, 32'd0, 4'd0); tick();
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        set_in(32'h7f08, 32'd0, 4'd0);
        chk("midrst_count", dataIn, 32'd0);
        set_in(32'h10, 32'd0, 4'd0);
        chk("midrst_dm", dataIn, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) extInt = ~extInt;
            r = $urandom_range(0, 9);
            if (r <= 2)      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            else if (r == 3) a = 32'h2ffc + 32'($urandom_range(0, 1)) * 4;
            else if (r <= 7) a = 32'h7f00 + 32'($urandom_range(0, 7)) * 4;
            else if (r == 8) a = 32'h7f20 + 32'($urandom_range(0, 7));
            else             a = $urandom;
            wd = (a >= 32'h7f00 && a < 32'h7f20) ? 32'($urandom_range(0, 15)) : $urandom;
            r = $urandom_range(0, 7);
            if (r <= 2)      be = 4'd0;
            else if (r <= 5) be = 4'hf;
            else             be = 4'($urandom_range(1, 14));
            set_in(a, wd, be);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
